// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity receive path.
`timescale 1ns/1ps
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  localparam logic        PARITY_EVEN    = 1'b0;
  localparam logic        PARITY_ODD_SEL = 1'b1;
  localparam int unsigned ERR_CNT_W      = 8;

  // A frame is good when data parity, received parity bit and the odd/even selector cancel out.
  function automatic logic parity_mismatch(input logic running, input logic rx_parity,
                                           input logic odd_sel);
    return running ^ rx_parity ^ odd_sel;
  endfunction

endpackage

// File: rtl/parity_accumulator.sv
// Serial counterpart of the XOR-chain parity generator: folds one bit per enabled cycle.
`timescale 1ns/1ps
module parity_accumulator (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic d,
  output logic acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= 1'b0;
    end else if (clr) begin
      acc <= 1'b0;
    end else if (en) begin
      acc <= acc ^ d;
    end
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Receive-side serial parity checker: LSB-first data bits followed by one parity bit.
// Optional saturating error counter on err_count when PARITY_ERR_CNT_EN is defined.
`timescale 1ns/1ps
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 4,
  parameter logic        PARITY_ODD = PARITY_EVEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
`ifdef PARITY_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_count,
`endif
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  state_t            state;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic              running;
  logic              start_frame;
  logic              data_bit;
  logic              parity_bit;
  logic              frame_err;
  logic              last_data_bit;

  assign start_frame   = (state == IDLE) && frame_start;
  assign data_bit      = (state == DATA) && bit_valid;
  assign parity_bit    = (state == PARITY) && bit_valid;
  assign last_data_bit = (bit_cnt == CNT_W'(DATA_W - 1));
  assign frame_err     = parity_mismatch(running, bit_in, PARITY_ODD);
  assign busy          = (state != IDLE);

  parity_accumulator u_acc (
    .clk (clk),
    .rst (rst),
    .clr (start_frame),
    .en  (data_bit),
    .d   (bit_in),
    .acc (running)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            shift_q <= '0;
            bit_cnt <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_valid) begin
            // Right shift with new bit at the MSB lands bit 0 at data_out[0] after DATA_W bits.
            shift_q <= {bit_in, shift_q[DATA_W-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (last_data_bit) begin
              state <= PARITY;
            end
          end
        end
        PARITY: begin
          if (bit_valid) begin
            data_out   <= shift_q;
            parity_err <= frame_err;
            data_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PARITY_ERR_CNT_EN
  // Counts in step with parity_err so the new value is visible in the data_valid cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (parity_bit && frame_err && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end
`endif

endmodule
